// File: rtl/timer_arbiter.sv
// ---------------------------------------------------------------------------
// timer_arbiter
// A single delay timer shared by NREQ requesters. Requesters are granted
// round-robin. While a requester owns the timer, a prescaled tick counts its
// requested length down. The owner then receives a one-cycle done pulse.
// If the owner drops its request mid-service, the service is abandoned with
// no done pulse.
//
// Ports
//   clk        system clock, rising-edge active
//   nRst       asynchronous active-low reset
//   req        per-requester level request, held until done pulses
//   len        packed delay lengths, requester i at [i*CW +: CW]
//   prescale   tick divider maximum (one tick every prescale+1 cycles)
//   grant      one-hot timer owner, zero outside RUN
//   busy       high in RUN and DONE
//   done       one-cycle completion pulse to the owner
//   remaining  ticks left for the current owner, zero when idle
// ---------------------------------------------------------------------------
module timer_arbiter #(
    parameter int NREQ = 3,
    parameter int CW   = 7
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] len,
    input  logic [6:0]         prescale,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic [NREQ-1:0]    done,
    output logic [CW-1:0]      remaining
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_SPARE = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [IW-1:0]     owner_r, owner_s;
    logic [IW-1:0]     last_r, last_s;
    logic [CW-1:0]     rem_r, rem_s;
    logic [6:0]        pcnt_r, pcnt_s;
    logic [NREQ-1:0]   grant_r, grant_s;
    logic [NREQ-1:0]   done_r, done_s;
    logic              busy_r, busy_s;
    logic [IW-1:0]     win_s;
    logic [CW-1:0]     len_win_s;

    // Round-robin search starting just after the last served index.
    function automatic logic [IW-1:0] rr_pick(input logic [IW-1:0]   last,
                                              input logic [NREQ-1:0] mask);
        logic [IW-1:0] pick;
        logic          found;
        int            idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && mask[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Index to one-hot conversion.
    function automatic logic [NREQ-1:0] one_hot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] oh;
        for (int i = 0; i < NREQ; i++) begin
            oh[i] = (IW'(i) == idx);
        end
        return oh;
    endfunction

    // Winner selection and the winner's length slice.
    always_comb begin
        win_s     = rr_pick(last_r, req);
        len_win_s = {CW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == win_s) begin
                len_win_s = len[i*CW +: CW];
            end else begin
                len_win_s = len_win_s;
            end
        end
    end

    // Next-state, counters and next registered outputs.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        last_s  = last_r;
        rem_s   = rem_r;
        pcnt_s  = pcnt_r;
        case (state_r)
            ST_IDLE: begin
                pcnt_s = 7'd0;
                if (|req) begin
                    state_s = ST_RUN;
                    owner_s = win_s;
                    rem_s   = len_win_s;
                end else begin
                    rem_s   = {CW{1'b0}};
                end
            end
            ST_RUN: begin
                if (!req[owner_r]) begin
                    // Owner withdrew: abandon silently but still rotate.
                    state_s = ST_IDLE;
                    rem_s   = {CW{1'b0}};
                    pcnt_s  = 7'd0;
                    last_s  = owner_r;
                end else if (rem_r == {CW{1'b0}}) begin
                    // Zero-length request completes without a tick.
                    state_s = ST_DONE;
                    pcnt_s  = 7'd0;
                    last_s  = owner_r;
                end else if (pcnt_r > prescale) begin
                    // Prescale lowered below the count: restart, no tick.
                    pcnt_s  = 7'd0;
                end else if (pcnt_r == prescale) begin
                    pcnt_s = 7'd0;
                    if (rem_r == CW'(1)) begin
                        rem_s   = {CW{1'b0}};
                        state_s = ST_DONE;
                        last_s  = owner_r;
                    end else begin
                        rem_s   = rem_r - CW'(1);
                    end
                end else begin
                    pcnt_s = pcnt_r + 7'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                rem_s   = {CW{1'b0}};
                pcnt_s  = 7'd0;
            end
            default: begin
                state_s = ST_IDLE;
                rem_s   = {CW{1'b0}};
                pcnt_s  = 7'd0;
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        if (state_s == ST_RUN) begin
            grant_s = one_hot(owner_s);
        end else begin
            grant_s = {NREQ{1'b0}};
        end
        if (state_s == ST_DONE) begin
            done_s = one_hot(owner_s);
        end else begin
            done_s = {NREQ{1'b0}};
        end
        busy_s = (state_s == ST_RUN) || (state_s == ST_DONE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_r <= ST_IDLE;
            owner_r <= {IW{1'b0}};
            last_r  <= IW'(NREQ - 1);
            rem_r   <= {CW{1'b0}};
            pcnt_r  <= 7'd0;
            grant_r <= {NREQ{1'b0}};
            done_r  <= {NREQ{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            last_r  <= last_s;
            rem_r   <= rem_s;
            pcnt_r  <= pcnt_s;
            grant_r <= grant_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
        end
    end

    assign grant     = grant_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign remaining = rem_r;

endmodule

// File: tb/tb_timer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_timer_arbiter
// Directed scenarios followed by randomized services against a
// transaction-level reference (round-robin choice, service length
// len*(prescale+1), done/abort outcome).
// ---------------------------------------------------------------------------
module tb_timer_arbiter;

    localparam int NREQ = 3;
    localparam int CW   = 7;

    logic               clk;
    logic               nRst;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [6:0]         prescale;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic [NREQ-1:0]    done;
    logic [CW-1:0]      remaining;

    int checks = 0;
    int errors = 0;

    timer_arbiter #(.NREQ(NREQ), .CW(CW)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .req       (req),
        .len       (len),
        .prescale  (prescale),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; stimulus and sampling both happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input int v);
        len[i*CW +: CW] = CW'(v);
    endtask

    task automatic apply_reset();
        nRst = 1'b0;
        tick();
        nRst = 1'b1;
    endtask

    function automatic int rr(input int last_i, input int mask);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last_i + k) % NREQ;
            if (((mask >> idx) & 1) == 1) return idx;
        end
        return -1;
    endfunction

    function automatic logic [31:0] oh(input int i);
        return 32'd1 << i;
    endfunction

    initial begin
        int n;
        int last;
        int p;
        int mask;
        int win;
        int elen;
        int erun;
        int ab;
        int abat;
        int exp_rr[4];

        nRst     = 1'b1;
        req      = '0;
        len      = '0;
        prescale = 7'd0;
        #2;
        nRst = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rem", 32'(remaining), 32'd0);
        tick();
        nRst = 1'b1;
        tick();

        // Single request: 2 ticks at prescale 3 -> 8 RUN cycles.
        prescale = 7'd3;
        set_len(0, 2);
        req = 3'b001;
        tick();
        chk("single_grant", 32'(grant), 32'd1);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_rem", 32'(remaining), 32'd2);
        n = 1;
        while (n < 100) begin
            tick();
            if (grant == 3'b000) break;
            n++;
        end
        chk("single_runlen", 32'(n), 32'd8);
        chk("single_done", 32'(done), 32'd1);
        chk("single_dbusy", 32'(busy), 32'd1);
        chk("single_drem", 32'(remaining), 32'd0);
        req = 3'b000;
        tick();
        chk("single_idle_busy", 32'(busy), 32'd0);
        chk("single_idle_done", 32'(done), 32'd0);

        // Round robin from reset with all requesters active.
        apply_reset();
        prescale = 7'd0;
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        exp_rr = '{1, 2, 4, 1};
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_grant", 32'(grant), 32'(exp_rr[k]));
            chk("rr_rem", 32'(remaining), 32'd1);
            tick();
            chk("rr_done", 32'(done), 32'(exp_rr[k]));
            chk("rr_dgrant", 32'(grant), 32'd0);
            tick();
            chk("rr_idle", 32'(busy), 32'd0);
            if (k == 3) req = 3'b000;
        end

        // Zero length on requester 1.
        set_len(1, 0);
        req = 3'b010;
        tick();
        chk("zero_grant", 32'(grant), 32'd2);
        chk("zero_rem", 32'(remaining), 32'd0);
        tick();
        chk("zero_done", 32'(done), 32'd2);
        chk("zero_dgrant", 32'(grant), 32'd0);
        chk("zero_drem", 32'(remaining), 32'd0);
        req = 3'b000;
        tick();
        chk("zero_idle", 32'(busy), 32'd0);

        // Abort after 3 RUN cycles, then requester 1 is served next.
        set_len(0, 5);
        prescale = 7'd1;
        req = 3'b001;
        tick();
        chk("abort_grant", 32'(grant), 32'd1);
        tick();
        tick();
        chk("abort_rem3", 32'(remaining), 32'd4);
        req = 3'b010;
        tick();
        chk("abort_grant0", 32'(grant), 32'd0);
        chk("abort_done0", 32'(done), 32'd0);
        chk("abort_busy0", 32'(busy), 32'd0);
        chk("abort_rem0", 32'(remaining), 32'd0);
        tick();
        chk("abort_next", 32'(grant), 32'd2);
        req = 3'b000;
        tick();
        chk("abort_next_idle", 32'(busy), 32'd0);

        // Prescale lowered from 9 to 2 while the counter is at 5.
        set_len(0, 3);
        prescale = 7'd9;
        req = 3'b001;
        tick();
        chk("pre_grant", 32'(grant), 32'd1);
        n = 1;
        while (n < 100) begin
            if (n == 6) begin
                chk("pre_rem6", 32'(remaining), 32'd3);
                prescale = 7'd2;
            end
            if (n == 7) chk("pre_rem7", 32'(remaining), 32'd3);
            if (n == 10) chk("pre_rem10", 32'(remaining), 32'd2);
            if (n == 13) chk("pre_rem13", 32'(remaining), 32'd1);
            tick();
            if (grant == 3'b000) break;
            n++;
        end
        chk("pre_runlen", 32'(n), 32'd15);
        chk("pre_done", 32'(done), 32'd1);
        req = 3'b000;
        tick();

        // Reset in the middle of a service.
        set_len(0, 6);
        prescale = 7'd0;
        req = 3'b001;
        tick();
        tick();
        tick();
        chk("mrst_rem", 32'(remaining), 32'd4);
        #2;
        nRst = 1'b0;
        #1;
        chk("mrst_grant", 32'(grant), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_rem0", 32'(remaining), 32'd0);
        req = 3'b011;
        tick();
        chk("mrst_hold_done", 32'(done), 32'd0);
        nRst = 1'b1;
        tick();
        chk("mrst_regrant", 32'(grant), 32'd1);
        req = 3'b000;
        tick();
        chk("mrst_abort_idle", 32'(busy), 32'd0);
        last = 0;

        // Randomized services against the transaction-level reference.
        for (int t = 0; t < 40; t++) begin
            p = int'($urandom_range(0, 3));
            prescale = 7'(p);
            for (int i = 0; i < NREQ; i++) set_len(i, int'($urandom_range(0, 5)));
            mask = int'($urandom_range(1, (1 << NREQ) - 1));
            req  = NREQ'(mask);
            win  = rr(last, mask);
            elen = int'(len[win*CW +: CW]);
            erun = (elen == 0) ? 1 : elen * (p + 1);
            ab   = (erun > 1 && $urandom_range(0, 3) == 0) ? 1 : 0;
            abat = (ab == 1) ? int'($urandom_range(1, erun - 1)) : 0;
            tick();
            chk("rnd_grant", 32'(grant), oh(win));
            chk("rnd_busy", 32'(busy), 32'd1);
            chk("rnd_rem", 32'(remaining), 32'(elen));
            n = 1;
            while (n < 600) begin
                if (ab == 1 && n == abat) begin
                    req[win] = 1'b0;
                    tick();
                    break;
                end
                // Disturb everything that must not matter to this service.
                for (int i = 0; i < NREQ; i++) begin
                    set_len(i, int'($urandom_range(0, 5)));
                    if (i != win) req[i] = 1'($urandom_range(0, 1));
                end
                tick();
                if (grant == 3'b000) break;
                n++;
            end
            if (ab == 1) begin
                chk("rnd_ab_grant", 32'(grant), 32'd0);
                chk("rnd_ab_done", 32'(done), 32'd0);
                chk("rnd_ab_busy", 32'(busy), 32'd0);
                chk("rnd_ab_rem", 32'(remaining), 32'd0);
            end else begin
                chk("rnd_runlen", 32'(n), 32'(erun));
                chk("rnd_done", 32'(done), oh(win));
                chk("rnd_dbusy", 32'(busy), 32'd1);
                chk("rnd_drem", 32'(remaining), 32'd0);
                req = 3'b000;
                tick();
                chk("rnd_idle_busy", 32'(busy), 32'd0);
                chk("rnd_idle_done", 32'(done), 32'd0);
            end
            last = win;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
